dds_period_meter: RTL and testbench
===================================

Name: dds_period_meter

Overview:
- Receive-side companion to the DDS line generator.
- Consumes the signed DDS sample stream and detects rising zero crossings with hysteresis.
- Measures the number of clocks between successive crossings and reports each period with a valid pulse.
- Flags lock when successive periods agree, and flags timeout when no crossing arrives.
- Used in self-check and closed-loop frequency verification of the DDS output.

Parameters:
- DATA_W, 8: sample width, two's complement.
- CNT_W, 16: period counter width. All-ones is the timeout value.
- HYST, 4: arm threshold. The detector arms when the sample is <= -HYST.
- LOCK_TOL, 1: maximum absolute difference between consecutive periods for lock.

Ports:
- CLK  in  1  processing clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SET  in  1  synchronous restart pulse, issued when the DDS step changes.
- sample_in  in  DATA_W  signed DDS value.
- sample_valid  in  1  qualifies sample_in. Invalid samples are ignored, but the counter still runs.
- crossing  out  1  one-cycle pulse on each accepted rising crossing.
- period  out  CNT_W  last measured period in CLK cycles. Held between updates.
- period_valid  out  1  one-cycle pulse when period updates.
- locked  out  1  consecutive periods within LOCK_TOL.
- timeout  out  1  sticky flag: counter saturated without a crossing.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to SEEK_ARM; counter=0; arm=0.
  - crossing=0, period=0, period_valid=0, locked=0, timeout=0.
- Crossing rule:
  - arm sets on an accepted sample <= -HYST.
  - A crossing is an accepted sample >= 0 while arm=1. arm clears on that same edge.
  - Samples in (-HYST, 0) never arm. Noise around zero produces no crossings.
- FSM states:
  - SEEK_ARM: wait for the arm condition, then go to SEEK_FIRST.
  - SEEK_FIRST: on the first crossing, counter<=1, go to MEAS_ARM. No period is reported.
  - MEAS_ARM: counter increments every clock. On the arm condition go to MEAS_CROSS.
  - MEAS_CROSS: counter increments every clock. On a crossing:
    - period<=counter, period_valid=1, counter<=1, go to MEAS_ARM.
- Period definition: period = number of CLK rising edges between the two accepted crossing samples.
- Latency: crossing, period_valid and the new period value appear on the registered outputs one cycle after the edge that accepts the crossing sample.
- Lock:
  - On each period_valid, compare the new period with the previous one.
  - If |new - prev| <= LOCK_TOL, locked<=1; otherwise locked<=0.
  - The first period after SET or timeout cannot set lock.
- Timeout:
  - In MEAS_ARM or MEAS_CROSS, when the counter reaches all-ones: timeout<=1, locked<=0, counter<=0, go to SEEK_ARM.
  - No period_valid is issued on timeout.
  - timeout clears on the next accepted crossing or on SET.
- Counter: saturating, never wraps.
- SET:
  - Same effect as reset except that period holds its last value.
  - SET has priority over a simultaneous crossing or timeout: no crossing or period_valid pulse is issued that cycle.
- sample_valid=0: arm and crossing logic hold; counter continues.
- Reset mid-measurement: all state is discarded immediately; no partial period is reported.

Decomposition:
- Shared package dds_meter_pkg holds:
  - FSM state enum (SEEK_ARM, SEEK_FIRST, MEAS_ARM, MEAS_CROSS).
  - Default widths and the HYST/LOCK_TOL constants, shared with the DDS generator benches.
- Sub-module dds_zero_cross_det:
  - Contents: the arm register plus the compare logic, driven by sample_in, sample_valid, SET and HYST.
  - Output: a single-cycle cross_hit.
- The top level keeps the FSM, counter, lock and timeout logic.

Test Plan:
- Reset checks:
  - Assert RESET=0 mid-count during a running sawtooth: all outputs read 0 within the same cycle.
  - Release: no period_valid until two crossings have passed.
- Sawtooth -128..127, +1 per clock, sample_valid=1:
  - crossing every 256 clocks.
  - First period_valid carries period=256.
  - locked=1 after the second period_valid.
- Step change:
  - Issue a SET pulse, then switch to a +2 sawtooth.
  - locked drops immediately; period holds 256.
  - Next reported period=128; locked=1 after the second report.
- Noise hold-off:
  - Samples cycle -3, 0, 2, -1 indefinitely with CNT_W=8.
  - No crossing ever.
  - After the first valid crossing, timeout=1 at counter 255 and locked=0.
- Gated input:
  - +1 sawtooth advancing only when sample_valid=1, with sample_valid on alternate clocks.
  - period=512.
- SET coincidence: drive SET on the same edge as a crossing sample. crossing, period_valid and period stay unchanged, and the FSM returns to SEEK_ARM.

Source files
------------

// File: rtl/dds_meter_pkg.sv
// Shared definitions for the DDS period meter and the benches around the DDS generator.
package dds_meter_pkg;

  // Default sample and counter widths.
  localparam int DATA_W_DEF   = 8;
  localparam int CNT_W_DEF    = 16;

  // A sample at or below -HYST arms the crossing detector.
  localparam int HYST_DEF     = 4;

  // Largest period difference, in clocks, that still counts as locked.
  localparam int LOCK_TOL_DEF = 1;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    SEEK_ARM   = 2'd0,
    SEEK_FIRST = 2'd1,
    MEAS_ARM   = 2'd2,
    MEAS_CROSS = 2'd3
  } meter_state_e;

endpackage

// File: rtl/dds_zero_cross_det.sv
// Rising zero-crossing detector with hysteresis.
// The arm register is set by a sample at or below -HYST. A crossing is a
// sample at or above zero seen while armed. Samples between -HYST and zero
// never arm, so noise around zero cannot produce crossings.
module dds_zero_cross_det
  import dds_meter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HYST   = HYST_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SET,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     arm_hit,
  output logic                     armed,
  output logic                     cross_hit
);

  localparam logic signed [DATA_W-1:0] ARM_LVL = DATA_W'(-HYST);

  logic arm_q;
  logic arm_d;
  logic below_s;
  logic nonneg_s;

  // Compare the accepted sample against the thresholds and work out the next arm state.
  always_comb begin
    below_s   = (sample_in <= ARM_LVL);
    nonneg_s  = ~sample_in[DATA_W-1];
    arm_hit   = sample_valid & below_s & ~SET;
    cross_hit = sample_valid & nonneg_s & arm_q & ~SET;
    arm_d     = arm_q;
    if (SET) begin
      arm_d = 1'b0;
    end else if (cross_hit) begin
      arm_d = 1'b0;
    end else if (arm_hit) begin
      arm_d = 1'b1;
    end else begin
      arm_d = arm_q;
    end
  end

  // Arm register; cleared by reset, by a restart and by the crossing it enabled.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign armed = arm_q;

endmodule

// File: rtl/dds_period_meter.sv
// Period meter for the DDS sample stream: counts clocks between successive
// rising zero crossings, reports each period, tracks lock between
// consecutive periods and flags a sticky timeout when the counter saturates.
module dds_period_meter
  import dds_meter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int LOCK_TOL = LOCK_TOL_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SET,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     crossing,
  output logic [CNT_W-1:0]         period,
  output logic                     period_valid,
  output logic                     locked,
  output logic                     timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TOL     = CNT_W'(LOCK_TOL);

  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             crossing_q;
  logic             period_valid_q;
  logic             locked_q;
  logic             timeout_q;
  logic             have_prev_q;

  logic             arm_hit_s;
  logic             armed_s;
  logic             cross_hit_s;
  logic             cnt_max_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] diff_s;
  logic             within_tol_s;

  dds_zero_cross_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_det (
    .CLK          (CLK),
    .RESET        (RESET),
    .SET          (SET),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm_hit      (arm_hit_s),
    .armed        (armed_s),
    .cross_hit    (cross_hit_s)
  );

  // Saturating increment and distance between the running count and the last period.
  always_comb begin
    cnt_max_s = (cnt_q == CNT_MAX);
    if (cnt_max_s) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
    if (cnt_q >= period_q) begin
      diff_s = cnt_q - period_q;
    end else begin
      diff_s = period_q - cnt_q;
    end
    within_tol_s = have_prev_q & (diff_s <= TOL);
  end

  // Measurement FSM with counter, period, lock and timeout registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= SEEK_ARM;
      cnt_q          <= '0;
      period_q       <= '0;
      crossing_q     <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      have_prev_q    <= 1'b0;
    end else if (SET) begin
      // Restart wins over any crossing or timeout this cycle; period is kept.
      state_q        <= SEEK_ARM;
      cnt_q          <= '0;
      crossing_q     <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      have_prev_q    <= 1'b0;
    end else begin
      crossing_q     <= cross_hit_s;
      period_valid_q <= 1'b0;
      if (cross_hit_s) begin
        timeout_q <= 1'b0;
      end
      case (state_q)
        SEEK_ARM: begin
          cnt_q <= '0;
          if (cross_hit_s) begin
            // Still armed from before a timeout: treat as the first crossing.
            cnt_q   <= CNT_ONE;
            state_q <= MEAS_ARM;
          end else if (arm_hit_s || armed_s) begin
            state_q <= SEEK_FIRST;
          end
        end
        SEEK_FIRST: begin
          if (cross_hit_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= MEAS_ARM;
          end
        end
        MEAS_ARM, MEAS_CROSS: begin
          if (cnt_max_s) begin
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SEEK_ARM;
          end else if (state_q == MEAS_CROSS && cross_hit_s) begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            locked_q       <= within_tol_s;
            have_prev_q    <= 1'b1;
            cnt_q          <= CNT_ONE;
            state_q        <= MEAS_ARM;
          end else begin
            cnt_q <= cnt_inc_s;
            if (state_q == MEAS_ARM && arm_hit_s) begin
              state_q <= MEAS_CROSS;
            end
          end
        end
        default: begin
          state_q <= SEEK_ARM;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign crossing     = crossing_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_dds_period_meter.sv
// Self-checking bench for dds_period_meter: table-driven sawtooth runs plus
// hand-written sequences for reset, restart coincidence and timeout.
module tb_dds_period_meter;

  logic               CLK;
  logic               RESET;
  logic               SET;
  logic signed [7:0]  sample_in;
  logic               sample_valid;
  logic               crossing;
  logic [15:0]        period;
  logic               period_valid;
  logic               locked;
  logic               timeout;

  logic               set8;
  logic signed [7:0]  sample8;
  logic               valid8;
  logic               crossing8;
  logic [7:0]         period8;
  logic               pv8;
  logic               locked8;
  logic               timeout8;

  int n_checks;
  int n_pass;

  dds_period_meter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SET          (SET),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .crossing     (crossing),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  dds_period_meter #(.CNT_W(8)) dut8 (
    .CLK          (CLK),
    .RESET        (RESET),
    .SET          (set8),
    .sample_in    (sample8),
    .sample_valid (valid8),
    .crossing     (crossing8),
    .period       (period8),
    .period_valid (pv8),
    .locked       (locked8),
    .timeout      (timeout8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int step;
    bit gated;
    int ncyc;
    int exp_cross;
    int exp_pv;
    int exp_period;
    bit exp_lock1;
    bit exp_lock2;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t vt [3];
    logic signed [7:0] s;
    logic signed [7:0] noise [4];
    int ncross, npv, bad, cross_at_pv1, first_to;
    bit l1, l2;

    n_checks = 0;
    n_pass   = 0;
    noise[0] = -8'sd3; noise[1] = 8'sd0; noise[2] = 8'sd2; noise[3] = -8'sd1;

    vt[0] = '{step: 1, gated: 1'b0, ncyc: 1100, exp_cross: 4, exp_pv: 3, exp_period: 256, exp_lock1: 1'b0, exp_lock2: 1'b1};
    vt[1] = '{step: 2, gated: 1'b0, ncyc: 600,  exp_cross: 5, exp_pv: 4, exp_period: 128, exp_lock1: 1'b0, exp_lock2: 1'b1};
    vt[2] = '{step: 1, gated: 1'b1, ncyc: 2000, exp_cross: 4, exp_pv: 3, exp_period: 512, exp_lock1: 1'b0, exp_lock2: 1'b1};

    RESET = 1'b0; SET = 1'b0; sample_in = 8'sd0; sample_valid = 1'b0;
    set8 = 1'b0; sample8 = 8'sd0; valid8 = 1'b0;
    tick();
    tick();
    check("reset_period", period, 0);
    check("reset_flags", {crossing, period_valid, locked, timeout}, 0);
    RESET = 1'b1;
    tick();

    // Timeout on the narrow-counter instance under noise that never arms.
    sample8 = -8'sd128; valid8 = 1'b1;
    tick();
    sample8 = 8'sd0;
    tick();
    check("to_first_crossing", crossing8, 1);
    ncross = 0; npv = 0; first_to = -1;
    for (int i = 2; i <= 300; i++) begin
      sample8 = noise[(i - 2) % 4];
      tick();
      if (crossing8) ncross++;
      if (pv8) npv++;
      if (timeout8 && first_to < 0) first_to = i;
    end
    check("noise_crossings", ncross, 0);
    check("noise_pv", npv, 0);
    check("timeout_cycle", first_to, 256);
    check("timeout_sticky", timeout8, 1);
    check("timeout_locked", locked8, 0);
    sample8 = -8'sd4;
    tick();
    sample8 = 8'sd0;
    tick();
    check("hyst_edge_crossing", crossing8, 1);
    check("timeout_cleared", timeout8, 0);
    valid8 = 1'b0;

    // Table-driven sawtooth runs, each after reset or a restart pulse.
    for (int v = 0; v < 3; v++) begin
      if (v > 0) begin
        SET = 1'b1;
        tick();
        SET = 1'b0;
        check("set_locked_drop", locked, 0);
        check("set_period_hold", period, vt[v-1].exp_period);
      end
      s = -8'sd128; ncross = 0; npv = 0; bad = 0; cross_at_pv1 = -1; l1 = 1'b0; l2 = 1'b0;
      for (int i = 0; i < vt[v].ncyc; i++) begin
        sample_in    = s;
        sample_valid = vt[v].gated ? (i % 2 == 0) : 1'b1;
        tick();
        if (sample_valid) s = s + 8'(vt[v].step);
        if (crossing) ncross++;
        if (period_valid) begin
          npv++;
          if (period != 16'(vt[v].exp_period)) begin
            bad++;
            $display("FAIL vec%0d_period: got %0d expected %0d", v, period, vt[v].exp_period);
          end
          if (npv == 1) begin l1 = locked; cross_at_pv1 = ncross; end
          if (npv == 2) l2 = locked;
        end
      end
      check($sformatf("vec%0d_crossings", v), ncross, vt[v].exp_cross);
      check($sformatf("vec%0d_reports", v), npv, vt[v].exp_pv);
      check($sformatf("vec%0d_period_errors", v), bad, 0);
      check($sformatf("vec%0d_first_report_after", v), cross_at_pv1, 2);
      check($sformatf("vec%0d_lock1", v), l1, vt[v].exp_lock1);
      check($sformatf("vec%0d_lock2", v), l2, vt[v].exp_lock2);
    end

    // Asynchronous reset in the middle of a running measurement.
    #2;
    RESET = 1'b0;
    #1;
    check("midrst_period", period, 0);
    check("midrst_locked", locked, 0);
    check("midrst_flags", {crossing, period_valid, timeout}, 0);
    RESET = 1'b1;
    tick();

    // Restart on the same edge as a crossing sample.
    s = -8'sd128; sample_valid = 1'b1;
    for (int i = 0; i <= 1160; i++) begin
      sample_in = s;
      SET = (i == 640);
      tick();
      SET = 1'b0;
      s = s + 8'sd1;
      if (i == 384) check("coin_pre_period", period, 256);
      if (i == 640) begin
        check("coin_crossing", crossing, 0);
        check("coin_pv", period_valid, 0);
        check("coin_period_hold", period, 256);
      end
      if (i == 896) begin
        check("coin_reseek_crossing", crossing, 1);
        check("coin_reseek_pv", period_valid, 0);
      end
      if (i == 1152) begin
        check("coin_next_pv", period_valid, 1);
        check("coin_next_period", period, 256);
        check("coin_next_locked", locked, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
